// File: rtl/rr_dispatch.sv
// rr_dispatch: one upstream stream is handed to exactly one of NumOut outputs.
// The target is picked round-robin among enabled outputs. Once a beat is
// offered, the target is locked until that beat is taken, so valid_o and
// data_o stay stable. An optional one-entry spill buffer decouples ready_o
// from the downstream ready_i.
module rr_dispatch #(
    parameter int unsigned  NumOut    = 4,
    parameter int unsigned  DataWidth = 32,
    parameter type          DataType  = logic [DataWidth-1:0],
    parameter bit           ExtPrio   = 1'b0,
    parameter bit           SpillReg  = 1'b0,
    localparam int unsigned IdxWidth  = (NumOut > 1) ? $clog2(NumOut) : 1,
    localparam type         idx_t     = logic [IdxWidth-1:0]
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  idx_t              rr_i,
    input  logic [NumOut-1:0] en_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  DataType           data_i,
    output logic [NumOut-1:0] valid_o,
    input  logic [NumOut-1:0] ready_i,
    output DataType           data_o,
    output idx_t              idx_o
);

    logic              stage_valid_s;
    DataType           stage_data_s;
    logic [NumOut-1:0] en_eff_s;
    idx_t              rr_s;
    idx_t              target_s;
    idx_t              cand_s;
    idx_t              rr_next_s;
    idx_t              nxt_cand_s;
    logic              has_target_s;
    logic              valid_out_s;
    logic              ready_sel_s;
    logic              hs_s;

    idx_t              rr_q, rr_d;
    logic              lock_q, lock_d;
    idx_t              lock_idx_q, lock_idx_d;

    // A single output has nothing to choose between, so its enable is ignored.
    assign en_eff_s = (NumOut == 1) ? {NumOut{1'b1}} : en_i;
    assign rr_s     = ExtPrio ? rr_i : rr_q;

    // Target: the held lock index, else the first enabled output from rr on.
    // Offsets are scanned high to low so the smallest matching offset wins.
    always_comb begin
        target_s = idx_t'((32'(rr_s)) % NumOut);
        cand_s   = target_s;
        for (int unsigned n = 0; n < NumOut; n++) begin
            cand_s   = idx_t'((32'(rr_s) + (NumOut - 1 - n)) % NumOut);
            target_s = en_eff_s[cand_s] ? cand_s : target_s;
        end
        target_s = lock_q ? lock_idx_q : target_s;
    end

    // Successor pointer: first enabled output strictly after the target,
    // falling back to the target itself when it is the only one enabled.
    always_comb begin
        rr_next_s  = target_s;
        nxt_cand_s = target_s;
        for (int unsigned n = 0; n + 1 < NumOut; n++) begin
            nxt_cand_s = idx_t'((32'(target_s) + (NumOut - 1 - n)) % NumOut);
            rr_next_s  = en_eff_s[nxt_cand_s] ? nxt_cand_s : rr_next_s;
        end
    end

    assign has_target_s = lock_q | (|en_eff_s);
    assign valid_out_s  = stage_valid_s & has_target_s;
    assign ready_sel_s  = ready_i[target_s];
    assign hs_s         = valid_out_s & ready_sel_s;

    // One-hot valid per output; reset removes it immediately.
    for (genvar k = 0; k < NumOut; k++) begin : g_valid
        assign valid_o[k] = rst_ni & valid_out_s & (target_s == idx_t'(k));
    end

    assign data_o = stage_data_s;
    assign idx_o  = target_s;

    // Pointer and lock update; flush wins over a same-cycle handshake.
    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (flush_i) begin
            rr_d       = '0;
            lock_d     = 1'b0;
            lock_idx_d = '0;
        end else if (hs_s) begin
            lock_d = 1'b0;
            rr_d   = ExtPrio ? rr_q : rr_next_s;
        end else if (valid_out_s) begin
            lock_d     = 1'b1;
            lock_idx_d = target_s;
        end else begin
            lock_d = lock_q;
        end
    end

    // Pointer and lock registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    if (SpillReg) begin : g_spill
        logic    full_q, full_d;
        DataType buf_q, buf_d;

        // Accept whenever the slot is empty or is being drained this cycle.
        assign ready_o       = ~full_q | hs_s;
        assign stage_valid_s = full_q;
        assign stage_data_s  = buf_q;

        // Buffer fill/drain; a write during a drain keeps it full with new data.
        always_comb begin
            full_d = full_q;
            buf_d  = buf_q;
            if (flush_i) begin
                full_d = 1'b0;
            end else if (valid_i && ready_o) begin
                full_d = 1'b1;
                buf_d  = data_i;
            end else if (hs_s) begin
                full_d = 1'b0;
            end else begin
                full_d = full_q;
            end
        end

        // Buffer registers.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                full_q <= 1'b0;
                buf_q  <= '0;
            end else begin
                full_q <= full_d;
                buf_q  <= buf_d;
            end
        end
    end else begin : g_pass
        assign stage_valid_s = valid_i;
        assign stage_data_s  = data_i;
        assign ready_o       = ready_sel_s & has_target_s;
    end

endmodule

// File: tb/tb_rr_dispatch.sv
// Directed bench for rr_dispatch: pass-through (dut0), spill-buffer (dut1)
// and single-output (dut2) configurations driven from shared stimulus.
module tb_rr_dispatch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       valid;
    logic [7:0] data;
    logic [3:0] en;
    logic [3:0] rdy;
    logic [1:0] rr_ext;

    logic       ro0, ro1, ro2;
    logic [3:0] vo0, vo1;
    logic [0:0] vo2;
    logic [7:0] do0, do1, do2;
    logic [1:0] idx0, idx1;
    logic [0:0] idx2;
    logic [0:0] en2, rdy2, rr2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_dispatch #(.NumOut(4), .DataWidth(8), .SpillReg(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rr_i(rr_ext), .en_i(en),
        .valid_i(valid), .ready_o(ro0), .data_i(data), .valid_o(vo0),
        .ready_i(rdy), .data_o(do0), .idx_o(idx0)
    );

    rr_dispatch #(.NumOut(4), .DataWidth(8), .SpillReg(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rr_i(rr_ext), .en_i(en),
        .valid_i(valid), .ready_o(ro1), .data_i(data), .valid_o(vo1),
        .ready_i(rdy), .data_o(do1), .idx_o(idx1)
    );

    rr_dispatch #(.NumOut(1), .DataWidth(8), .SpillReg(1'b0)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rr_i(rr2), .en_i(en2),
        .valid_i(valid), .ready_o(ro2), .data_i(data), .valid_o(vo2),
        .ready_i(rdy2), .data_o(do2), .idx_o(idx2)
    );

    typedef struct {
        logic [3:0] en;
        logic       vld;
        logic [3:0] rdy;
        logic [7:0] dat;
        logic [3:0] e_vo;
        logic [1:0] e_idx;
        logic       chk_idx;
        logic       e_rdy;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        valid = 1'b0;
        next_cycle();
        flush = 1'b0;
    endtask

    initial begin
        // Sequential vectors for dut0, state carried from row to row.
        vt[0]  = '{4'hF, 1'b1, 4'hF, 8'h10, 4'b0001, 2'd0, 1'b1, 1'b1};
        vt[1]  = '{4'hF, 1'b1, 4'hF, 8'h11, 4'b0010, 2'd1, 1'b1, 1'b1};
        vt[2]  = '{4'hF, 1'b1, 4'hF, 8'h12, 4'b0100, 2'd2, 1'b1, 1'b1};
        vt[3]  = '{4'hF, 1'b1, 4'hF, 8'h13, 4'b1000, 2'd3, 1'b1, 1'b1};
        vt[4]  = '{4'hF, 1'b1, 4'hF, 8'h14, 4'b0001, 2'd0, 1'b1, 1'b1};
        vt[5]  = '{4'hA, 1'b1, 4'hF, 8'h15, 4'b0010, 2'd1, 1'b1, 1'b1};
        vt[6]  = '{4'hA, 1'b1, 4'hF, 8'h16, 4'b1000, 2'd3, 1'b1, 1'b1};
        vt[7]  = '{4'hA, 1'b1, 4'hF, 8'h17, 4'b0010, 2'd1, 1'b1, 1'b1};
        vt[8]  = '{4'h0, 1'b1, 4'hF, 8'h18, 4'b0000, 2'd0, 1'b0, 1'b0};
        vt[9]  = '{4'h0, 1'b1, 4'hF, 8'h19, 4'b0000, 2'd0, 1'b0, 1'b0};
        vt[10] = '{4'hF, 1'b0, 4'hF, 8'h1A, 4'b0000, 2'd3, 1'b1, 1'b1};
        vt[11] = '{4'h1, 1'b1, 4'hF, 8'h1B, 4'b0001, 2'd0, 1'b1, 1'b1};
        vt[12] = '{4'h1, 1'b1, 4'hF, 8'h1C, 4'b0001, 2'd0, 1'b1, 1'b1};
        vt[13] = '{4'hF, 1'b1, 4'hE, 8'h1D, 4'b0001, 2'd0, 1'b1, 1'b0};
        vt[14] = '{4'hE, 1'b1, 4'hE, 8'h1D, 4'b0001, 2'd0, 1'b1, 1'b0};
        vt[15] = '{4'hE, 1'b1, 4'hF, 8'h1D, 4'b0001, 2'd0, 1'b1, 1'b1};
        vt[16] = '{4'hF, 1'b1, 4'hF, 8'h1E, 4'b0010, 2'd1, 1'b1, 1'b1};

        rst_n  = 1'b0;
        flush  = 1'b0;
        valid  = 1'b1;
        data   = 8'h00;
        en     = 4'hF;
        rdy    = 4'hF;
        rr_ext = 2'd0;
        en2    = 1'b0;
        rdy2   = 1'b1;
        rr2    = 1'b0;

        // Reset state: no valid anywhere while reset is held.
        #12;
        chk("rst_vo0", 32'(vo0), 32'h0);
        chk("rst_vo1", 32'(vo1), 32'h0);
        chk("rst_vo2", 32'(vo2), 32'h0);
        chk("rst_idx0", 32'(idx0), 32'h0);
        rst_n = 1'b1;
        valid = 1'b0;
        #1;
        chk("post_rst_ro1", 32'(ro1), 32'h1);
        next_cycle();

        // Table-driven run on dut0.
        for (int i = 0; i < 17; i++) begin
            en    = vt[i].en;
            valid = vt[i].vld;
            rdy   = vt[i].rdy;
            data  = vt[i].dat;
            #1;
            chk($sformatf("vec%0d_vo", i), 32'(vo0), 32'(vt[i].e_vo));
            chk($sformatf("vec%0d_ro", i), 32'(ro0), 32'(vt[i].e_rdy));
            if (vt[i].chk_idx) chk($sformatf("vec%0d_idx", i), 32'(idx0), 32'(vt[i].e_idx));
            if (vt[i].vld) chk($sformatf("vec%0d_do", i), 32'(do0), 32'(vt[i].dat));
            next_cycle();
        end

        // Single output: enable ignored, ready follows ready_i[0].
        valid = 1'b1;
        data  = 8'h3C;
        en2   = 1'b0;
        rdy2  = 1'b1;
        #1;
        chk("n1_vo", 32'(vo2), 32'h1);
        chk("n1_ro", 32'(ro2), 32'h1);
        chk("n1_idx", 32'(idx2), 32'h0);
        chk("n1_do", 32'(do2), 32'h3C);
        rdy2 = 1'b0;
        #1;
        chk("n1_ro_low", 32'(ro2), 32'h0);
        chk("n1_vo_hold", 32'(vo2), 32'h1);
        next_cycle();

        // Stalled beat on output 0, enable drops mid-stall, then taken.
        do_flush();
        for (int c = 1; c <= 4; c++) begin
            valid = 1'b1;
            data  = 8'hA5;
            en    = (c == 1) ? 4'hF : 4'hE;
            rdy   = (c == 4) ? 4'hF : 4'hE;
            #1;
            chk($sformatf("stall%0d_vo", c), 32'(vo0), 32'h1);
            chk($sformatf("stall%0d_do", c), 32'(do0), 32'hA5);
            chk($sformatf("stall%0d_ro", c), 32'(ro0), (c == 4) ? 32'h1 : 32'h0);
            next_cycle();
        end
        en   = 4'hF;
        data = 8'h5A;
        #1;
        chk("stall_next_idx", 32'(idx0), 32'h1);
        chk("stall_next_vo", 32'(vo0), 32'h2);
        next_cycle();

        // Spill buffer: four back-to-back beats, one cycle later, no bubbles.
        do_flush();
        en  = 4'hF;
        rdy = 4'hF;
        for (int c = 0; c <= 5; c++) begin
            valid = (c < 4);
            data  = 8'(c + 1);
            #1;
            chk($sformatf("spill%0d_ro", c), 32'(ro1), 32'h1);
            if (c >= 1 && c <= 4) begin
                chk($sformatf("spill%0d_vo", c), 32'(vo1), 32'h1 << (c - 1));
                chk($sformatf("spill%0d_do", c), 32'(do1), 32'(c));
                chk($sformatf("spill%0d_idx", c), 32'(idx1), 32'(c - 1));
            end else begin
                chk($sformatf("spill%0d_vo", c), 32'(vo1), 32'h0);
            end
            next_cycle();
        end

        // Spill buffer: move rr, lock on output 2, flush clears everything.
        do_flush();
        valid = 1'b1; data = 8'h11; en = 4'hF; rdy = 4'hF;
        #1;
        chk("lk0_ro", 32'(ro1), 32'h1);
        next_cycle();
        valid = 1'b1; data = 8'h77;
        #1;
        chk("lk1_vo", 32'(vo1), 32'h1);
        chk("lk1_do", 32'(do1), 32'h11);
        next_cycle();
        valid = 1'b0; en = 4'b0100; rdy = 4'h0;
        #1;
        chk("lk2_vo", 32'(vo1), 32'h4);
        chk("lk2_idx", 32'(idx1), 32'h2);
        chk("lk2_do", 32'(do1), 32'h77);
        chk("lk2_ro", 32'(ro1), 32'h0);
        next_cycle();
        en = 4'b0001;
        #1;
        chk("lk3_vo_held", 32'(vo1), 32'h4);
        chk("lk3_idx_held", 32'(idx1), 32'h2);
        flush = 1'b1;
        next_cycle();
        flush = 1'b0; en = 4'hF;
        #1;
        chk("fl_vo", 32'(vo1), 32'h0);
        chk("fl_ro", 32'(ro1), 32'h1);
        chk("fl_idx", 32'(idx1), 32'h0);

        // Reset in the middle of a lock drops valid at once.
        valid = 1'b1; data = 8'h99; en = 4'b0100; rdy = 4'h0;
        next_cycle();
        valid = 1'b0;
        #1;
        chk("rl_vo_before", 32'(vo1), 32'h4);
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk("rl_vo1", 32'(vo1), 32'h0);
        chk("rl_vo0", 32'(vo0), 32'h0);
        #2;
        rst_n = 1'b1;
        next_cycle();
        chk("rl_after_vo1", 32'(vo1), 32'h0);
        chk("rl_after_ro1", 32'(ro1), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_dispatch.md
RR_DISPATCH -- requirements
Module: rr_dispatch

Interface
REQ-001 SHALL have parameter NumOut, default 4, number of output ports (>=1).
REQ-002 SHALL have parameter DataWidth, default 32, payload width when DataType is not overridden.
REQ-003 SHALL have parameter DataType, default logic [DataWidth-1:0], payload type.
REQ-004 SHALL have parameter ExtPrio, default 1'b0; when 1, rr_i replaces the internal pointer.
REQ-005 SHALL have parameter SpillReg, default 1'b0; when 1, a one-entry input buffer is inserted.
REQ-006 SHALL have derived parameter IdxWidth = (NumOut>1) ? $clog2(NumOut) : 1 and type idx_t = logic [IdxWidth-1:0]; neither is overridden.
REQ-007 SHALL have port clk_i, input, 1, clock, rising edge.
REQ-008 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port flush_i, input, 1, synchronous clear of pointer, lock and buffer.
REQ-010 SHALL have port rr_i, input, idx_t, external priority pointer, used only when ExtPrio=1.
REQ-011 SHALL have port en_i, input, NumOut, per-output enable mask.
REQ-012 SHALL have port valid_i, input, 1, upstream valid.
REQ-013 SHALL have port ready_o, output, 1, upstream ready.
REQ-014 SHALL have port data_i, input, DataType, upstream payload.
REQ-015 SHALL have port valid_o, output, NumOut, per-output valid, onehot0.
REQ-016 SHALL have port ready_i, input, NumOut, per-output ready.
REQ-017 SHALL have port data_o, output, DataType, payload broadcast to all outputs.
REQ-018 SHALL have port idx_o, output, idx_t, index of the currently targeted output.

Function
REQ-019 Stage valid/data SHALL be valid_i/data_i when SpillReg=0 and buffer full/contents when SpillReg=1.
REQ-020 Pointer rr SHALL be rr_q (internal) when ExtPrio=0 and rr_i when ExtPrio=1.
REQ-021 When unlocked, target SHALL be the first index with en_i set, searching cyclically from rr inclusive; when locked, target SHALL be lock_idx_q.
REQ-022 idx_o SHALL equal the target; valid_o[target] SHALL equal stage valid and all other valid_o bits SHALL be 0.
REQ-023 When unlocked and en_i is all zero, valid_o SHALL be 0 and no transfer SHALL occur.
REQ-024 valid_o SHALL NOT depend combinationally on ready_i.
REQ-025 An output handshake SHALL occur when valid_o[k] && ready_i[k].
REQ-026 When valid_o is asserted without a handshake, lock_q SHALL be set and lock_idx_q SHALL capture the target; lock_q SHALL clear on the handshake.
REQ-027 While locked, the target SHALL NOT change, even if en_i[target] drops or rr_i changes.
REQ-028 On a handshake with ExtPrio=0, rr_q SHALL load the first enabled index strictly after the target, cyclically, wrapping NumOut-1 -> 0.
REQ-029 If no other index is enabled, rr_q SHALL keep the target index.
REQ-030 With SpillReg=0, ready_o SHALL equal ready_i[target] && (locked || |en_i); latency 0; upstream SHALL hold data_i stable while valid_i && !ready_o.
REQ-031 With SpillReg=1, ready_o SHALL equal !full || output handshake, buffer writes SHALL occur on valid_i && ready_o, latency SHALL be 1 cycle, and one beat per cycle SHALL be sustained with no bubbles.
REQ-032 Simultaneous buffer write and output handshake SHALL keep the buffer full with the new data.
REQ-033 When NumOut=1, the block SHALL pass through: valid_o[0]=stage valid, ready_o derives from ready_i[0], idx_o=0, and en_i is ignored.
REQ-034 A flush SHALL clear rr_q to 0, clear lock_q and empty the buffer on the next edge; flush has priority over a simultaneous handshake.

Reset
REQ-035 While rst_ni is low: rr_q=0, lock_q=0, lock_idx_q=0, buffer empty, valid_o=0.
REQ-036 Out of reset, ready_o SHALL be 1 when SpillReg=1, and per REQ-030 when SpillReg=0.
REQ-037 Reset asserted mid-lock SHALL drop valid_o immediately (asynchronously) with no transfer.

Verification
REQ-038 NumOut=4, en_i=4'b1111, all ready_i high, 5 beats -> idx_o sequence 0,1,2,3,0, one handshake per cycle.
REQ-039 en_i=4'b1010, all ready high, 3 beats -> idx_o sequence 1,3,1.
REQ-040 Beat 0xA5, ready_i[0]=0 for 3 cycles, en_i[0] dropped in cycle 2 -> valid_o=4'b0001, data_o=0xA5 held stable; handshake in cycle 4; next idx_o=1.
REQ-041 SpillReg=0, en_i=0, valid_i=1 -> valid_o=0, ready_o=0 indefinitely.
REQ-042 SpillReg=1, beats 0x1..0x4 back-to-back, all ready -> outputs 0x1..0x4 on consecutive cycles starting 1 cycle later, ready_o held at 1 throughout.
REQ-043 Lock on idx 2, then flush_i for 1 cycle -> next cycle valid_o=0 (SpillReg=1), rr_q=0, lock_q=0.
